instr_queue_decode: RTL and testbench

//   Multi-entry instruction register: buffers fetched 32-bit instruction words in a FIFO.

---
 rtl/instr_queue_decode_pkg.sv | 26 ++
 rtl/instr_queue_decode_fields.sv | 45 ++++
 rtl/instr_queue_decode.sv | 83 ++++++++
 tb/tb_instr_queue_decode.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/instr_queue_decode_pkg.sv
// instr_queue_decode_pkg: shared format codes, widths and field bit ranges.
// Ports: none (package imported by instr_queue_decode and instr_queue_decode_fields).
package instr_queue_decode_pkg;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 2;
    localparam logic [OPC_W-1:0] FMT_R   = 2'b00;
    localparam logic [OPC_W-1:0] FMT_I   = 2'b01;
    localparam logic [OPC_W-1:0] FMT_J   = 2'b10;
    localparam logic [OPC_W-1:0] FMT_ILL = 2'b11;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 30;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int SA_HI   = 10;
    localparam int SA_LO   = 6;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 25;
    localparam int ADDR_LO = 0;
endpackage

// File: rtl/instr_queue_decode_fields.sv
// instr_queue_decode_fields: combinational decode of the head word into format-gated fields.
// Ports: i_valid/i_instr (head entry) -> o_fmt, o_illegal, o_rs, o_rt, o_rd, o_sa, o_func,
//        o_imm, o_imm_ext (sign- or zero-extended per SEXT_IMM), o_addr. All zero when invalid.
module instr_queue_decode_fields
    import instr_queue_decode_pkg::*;
#(
    parameter bit SEXT_IMM = 1'b1
) (
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPC_W-1:0]   o_fmt,
    output logic               o_illegal,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_sa,
    output logic [5:0]         o_func,
    output logic [15:0]        o_imm,
    output logic [31:0]        o_imm_ext,
    output logic [25:0]        o_addr
);
    logic [OPC_W-1:0] w_fmt;
    logic             w_r;
    logic             w_i;
    logic             w_j;
    logic [15:0]      w_imm;

    always_comb begin
        w_fmt     = i_valid ? i_instr[OPC_HI:OPC_LO] : FMT_R;
        w_r       = i_valid && (w_fmt == FMT_R);
        w_i       = i_valid && (w_fmt == FMT_I);
        w_j       = i_valid && (w_fmt == FMT_J);
        w_imm     = i_instr[IMM_HI:IMM_LO];
        o_fmt     = w_fmt;
        o_illegal = i_valid && (w_fmt == FMT_ILL);
        o_rs      = (w_r || w_i) ? i_instr[RS_HI:RS_LO] : '0;
        o_rt      = (w_r || w_i) ? i_instr[RT_HI:RT_LO] : '0;
        o_rd      = w_r ? i_instr[RD_HI:RD_LO] : '0;
        o_sa      = w_r ? i_instr[SA_HI:SA_LO] : '0;
        o_func    = w_r ? i_instr[FUNC_HI:FUNC_LO] : '0;
        o_imm     = w_i ? w_imm : '0;
        o_imm_ext = !w_i ? '0 : SEXT_IMM ? {{16{w_imm[15]}}, w_imm} : {16'h0, w_imm};
        o_addr    = w_j ? i_instr[ADDR_HI:ADDR_LO] : '0;
    end
endmodule

// File: rtl/instr_queue_decode.sv
// instr_queue_decode: DEPTH-entry instruction FIFO with valid/ready handshakes, flush and head decode.
// Ports: clk, rst_n (async active-low); i_flush; fetch side i_in_valid/o_in_ready/i_in_instr;
//        consumer side o_out_valid/i_out_ready; decoded head fields o_fmt..o_addr; o_count occupancy.
module instr_queue_decode
    import instr_queue_decode_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit SEXT_IMM = 1'b1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [INSTR_W-1:0] i_in_instr,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [OPC_W-1:0]   o_fmt,
    output logic               o_illegal,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_sa,
    output logic [5:0]         o_func,
    output logic [15:0]        o_imm,
    output logic [31:0]        o_imm_ext,
    output logic [25:0]        o_addr,
    output logic [CW-1:0]      o_count
);
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_push;
    logic               w_pop;

    // in_ready depends only on occupancy, so a full queue refuses a push even when popping
    assign o_in_ready  = r_count < CW'(DEPTH);
    assign o_out_valid = r_count != '0;
    assign o_count     = r_count;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    // storage is deliberately left out of reset; outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    instr_queue_decode_fields #(
        .SEXT_IMM (SEXT_IMM)
    ) u_fields (
        .i_valid   (o_out_valid),
        .i_instr   (r_mem[r_rd_ptr]),
        .o_fmt     (o_fmt),
        .o_illegal (o_illegal),
        .o_rs      (o_rs),
        .o_rt      (o_rt),
        .o_rd      (o_rd),
        .o_sa      (o_sa),
        .o_func    (o_func),
        .o_imm     (o_imm),
        .o_imm_ext (o_imm_ext),
        .o_addr    (o_addr)
    );
endmodule

// File: tb/tb_instr_queue_decode.sv
// tb_instr_queue_decode: directed and random checks of the instruction queue against a queue model.
module tb_instr_queue_decode;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid, illegal;
    logic [1:0]  fmt;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [31:0] imm_ext;
    logic [25:0] addr;
    logic [2:0]  count;
    logic        z_in_ready, z_out_valid, z_illegal;
    logic [1:0]  z_fmt;
    logic [4:0]  z_rs, z_rt, z_rd, z_sa;
    logic [5:0]  z_func;
    logic [15:0] z_imm;
    logic [31:0] z_imm_ext;
    logic [25:0] z_addr;
    logic [2:0]  z_count;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    instr_queue_decode #(.DEPTH(DEPTH), .SEXT_IMM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_instr(in_instr), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_fmt(fmt),
        .o_illegal(illegal), .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_sa(sa), .o_func(func),
        .o_imm(imm), .o_imm_ext(imm_ext), .o_addr(addr), .o_count(count)
    );

    instr_queue_decode #(.DEPTH(DEPTH), .SEXT_IMM(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(z_in_ready),
        .i_in_instr(in_instr), .o_out_valid(z_out_valid), .i_out_ready(out_ready), .o_fmt(z_fmt),
        .o_illegal(z_illegal), .o_rs(z_rs), .o_rt(z_rt), .o_rd(z_rd), .o_sa(z_sa), .o_func(z_func),
        .o_imm(z_imm), .o_imm_ext(z_imm_ext), .o_addr(z_addr), .o_count(z_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        v;
        logic [31:0] h;
        logic [1:0]  f;
        logic        is_r, is_i, is_j;
        v    = q.size() != 0;
        h    = v ? q[0] : 32'd0;
        f    = v ? h[31:30] : 2'd0;
        is_r = v && f == 2'd0;
        is_i = v && f == 2'd1;
        is_j = v && f == 2'd2;
        chk({tag, ".count"}, 32'(count), q.size());
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".fmt"}, 32'(fmt), 32'(f));
        chk({tag, ".illegal"}, 32'(illegal), 32'(v && f == 2'd3));
        chk({tag, ".rs"}, 32'(rs), (is_r || is_i) ? (h >> 21) & 32'h1F : 32'd0);
        chk({tag, ".rt"}, 32'(rt), (is_r || is_i) ? (h >> 16) & 32'h1F : 32'd0);
        chk({tag, ".rd"}, 32'(rd), is_r ? (h >> 11) & 32'h1F : 32'd0);
        chk({tag, ".sa"}, 32'(sa), is_r ? (h >> 6) & 32'h1F : 32'd0);
        chk({tag, ".func"}, 32'(func), is_r ? h & 32'h3F : 32'd0);
        chk({tag, ".imm"}, 32'(imm), is_i ? h & 32'hFFFF : 32'd0);
        chk({tag, ".imm_ext"}, imm_ext, is_i ? 32'($signed(h[15:0])) : 32'd0);
        chk({tag, ".imm_ext_z"}, z_imm_ext, is_i ? h & 32'hFFFF : 32'd0);
        chk({tag, ".addr"}, 32'(addr), is_j ? h & 32'h3FF_FFFF : 32'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f, input string tag);
        bit push, pop;
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush     = f;
        push = v && q.size() < DEPTH;
        pop  = r && q.size() != 0;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        step(1, 32'h3EB4_3C00, 1, 0, "t1");
        chk("t1.rs_lit", 32'(rs), 32'd21);
        chk("t1.rt_lit", 32'(rt), 32'd20);
        chk("t1.rd_lit", 32'(rd), 32'd7);
        chk("t1.sa_lit", 32'(sa), 32'd16);
        step(0, 32'h0, 1, 0, "t1_pop");
        step(1, 32'h57E0_E38F, 0, 0, "t2");
        chk("t2.imm_ext_lit", imm_ext, 32'hFFFF_E38F);
        chk("t2.imm_ext_z_lit", z_imm_ext, 32'h0000_E38F);
        chk("t2.rs_lit", 32'(rs), 32'd31);
        step(0, 32'h0, 1, 0, "t2_pop");
        step(1, 32'h82D5_D355, 0, 0, "t3j");
        chk("t3.addr_lit", 32'(addr), 32'h02D5_D355);
        step(1, 32'hC000_0000, 1, 0, "t3_pop_push");
        chk("t3.illegal_lit", 32'(illegal), 32'd1);
        step(0, 32'h0, 1, 0, "t3_pop");
        step(1, 32'h4000_1234, 0, 0, "t4_offset");
        step(0, 32'h0, 1, 0, "t4_offset_pop");
        for (int i = 0; i < 5; i++) step(1, $urandom(), 0, 0, "t4_fill");
        chk("t4.count_full", 32'(count), 32'd4);
        chk("t4.in_ready_full", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, "t4_drain");
        chk("t4.empty", 32'(out_valid), 32'd0);
        step(1, $urandom(), 0, 0, "t5_a");
        step(1, $urandom(), 0, 0, "t5_b");
        step(1, $urandom(), 1, 0, "t5_pushpop");
        chk("t5.count2", 32'(count), 32'd2);
        step(1, $urandom(), 0, 0, "t5_c");
        step(1, $urandom(), 0, 0, "t5_d");
        step(1, $urandom(), 1, 0, "t5_fullpop");
        chk("t5.count3", 32'(count), 32'd3);
        step(1, $urandom(), 1, 1, "t6_flush");
        chk("t6.count0", 32'(count), 32'd0);
        for (int i = 0; i < 600; i++) begin
            w = $urandom();
            step($urandom_range(0, 3) != 0, w,
                 (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 40) == 0, "rand");
        end
        step(1, 32'h4321_8765, 0, 0, "mid_a");
        step(1, 32'h0123_4567, 0, 0, "mid_b");
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        q.delete();
        check_all("rst_mid");
        chk("rst_mid.in_ready_lit", 32'(in_ready), 32'd1);
        chk("rst_mid.out_valid_lit", 32'(out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step(1, 32'h57E0_E38F, 0, 0, "post_rst");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
